// File: rtl/capture_axi_writer.sv
// capture_axi_writer
// Camera capture path. Samples an 8-bit parallel camera bus on clk, builds
// RGB565 pixels from byte pairs and expands them to 32-bit words. The words
// go into a pixel FIFO, and whole frames are written to VRAM as AXI4 INCR bursts.
// Ports:
//   aclk_i, aresetn_i        system clock, async active-low reset
//   resol_i                  frame size select (00 VGA, 01 XGA, 10 SXGA, 11 VGA)
//   pclk_i/href_i/vsync_i    camera strobes (asynchronous), camdata_i camera byte
//   wraddr_i/rdaddr_i, byteen_i, wren_i/rden_i, wdata_i, rdata_capt_o  register bus
//   cap_irq_o                frame-done interrupt (level)
//   cap_fifo_over_o/under_o  sticky FIFO error flags
//   m_axi_aw*/w*/b*          AXI4 write master (BREADY tied high)
// Frame FSM states:
//   ST_IDLE  | wait for CAPON and a VSYNC falling edge
//   ST_ARM   | latch frame size and VRAM base, flush the FIFO
//   ST_CAPT  | push pixels until the whole frame has been counted
//   ST_DRAIN | wait for the last burst response, then flag frame done
// Burst FSM states:
//   BS_IDLE  | wait for a full burst in the FIFO
//   BS_AW    | address phase
//   BS_W     | data beats
//   BS_B     | wait for write response
module capture_axi_writer #(
    parameter logic [31:0] MEMBASE    = 32'h2000_0000,
    parameter logic [15:0] REGBASE    = 16'h1000,
    parameter int          FIFO_DEPTH = 512,
    parameter int          BURST_LEN  = 16,
    parameter int          VGA_W = 640,  parameter int VGA_H = 480,
    parameter int          XGA_W = 1024, parameter int XGA_H = 768,
    parameter int          SXGA_W = 1280, parameter int SXGA_H = 1024
) (
    input  logic        aclk_i,
    input  logic        aresetn_i,
    input  logic [1:0]  resol_i,
    input  logic        pclk_i,
    input  logic        href_i,
    input  logic        vsync_i,
    input  logic [7:0]  camdata_i,
    input  logic [15:0] wraddr_i,
    input  logic [15:0] rdaddr_i,
    input  logic [3:0]  byteen_i,
    input  logic        wren_i,
    input  logic        rden_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_capt_o,
    output logic        cap_irq_o,
    output logic        cap_fifo_over_o,
    output logic        cap_fifo_under_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic [7:0]  m_axi_awlen_o,
    output logic [2:0]  m_axi_awsize_o,
    output logic [1:0]  m_axi_awburst_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wlast_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] BURST_CNT = (PW+1)'(BURST_LEN);
    localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [31:0] ADDR_STEP = 32'(BURST_LEN * 4);
    localparam logic [31:0] FW_VGA    = 32'(VGA_W * VGA_H);
    localparam logic [31:0] FW_XGA    = 32'(XGA_W * XGA_H);
    localparam logic [31:0] FW_SXGA   = 32'(SXGA_W * SXGA_H);
    localparam logic [15:0] A_CAPADDR = REGBASE;
    localparam logic [15:0] A_CAPCTRL = REGBASE + 16'h4;
    localparam logic [15:0] A_CAPINT  = REGBASE + 16'h8;
    localparam logic [15:0] A_CAPFIFO = REGBASE + 16'hC;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_ARM = 2'd1, ST_CAPT = 2'd2, ST_DRAIN = 2'd3;
    localparam logic [1:0] BS_IDLE = 2'd0, BS_AW = 2'd1, BS_W = 2'd2, BS_B = 2'd3;

    // ---------------- camera synchronizers ----------------
    logic [2:0] pclk_sq, vsync_sq;
    logic [1:0] href_sq;
    logic [7:0] dat_s1_q, dat_s2_q, byte0_q;
    logic       phase_q;
    logic       pclk_rise, vsync_fall, href_s, pix_valid;
    logic [15:0] pixel;
    logic [31:0] pix_word;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            pclk_sq  <= '0;
            vsync_sq <= '0;
            href_sq  <= '0;
            dat_s1_q <= '0;
            dat_s2_q <= '0;
        end else begin
            pclk_sq  <= {pclk_sq[1:0], pclk_i};
            vsync_sq <= {vsync_sq[1:0], vsync_i};
            href_sq  <= {href_sq[0], href_i};
            dat_s1_q <= camdata_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign pclk_rise  = pclk_sq[1] & ~pclk_sq[2];
    assign vsync_fall = ~vsync_sq[1] & vsync_sq[2];
    assign href_s     = href_sq[1];
    assign pix_valid  = href_s & pclk_rise & phase_q;
    assign pixel      = {byte0_q, dat_s2_q};
    // 5/6-bit channels widened by replicating their MSBs into the low bits
    assign pix_word   = {8'h00, pixel[15:11], pixel[15:13], pixel[10:5], pixel[10:9],
                         pixel[4:0], pixel[4:2]};

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            phase_q <= 1'b0;
            byte0_q <= '0;
        end else if (!href_s) begin
            phase_q <= 1'b0;
        end else if (pclk_rise) begin
            if (!phase_q) byte0_q <= dat_s2_q;
            phase_q <= ~phase_q;
        end
    end

    // ---------------- registers / state ----------------
    logic [31:0] capaddr_q, frame_words_q, frame_words_d, pix_cnt_q, awaddr_q, rdata_q;
    logic        capon_q, irqen_q, irqst_q, over_q, under_q;
    logic [1:0]  fst_q, bst_q;
    logic        awvalid_q, wvalid_q;
    logic [7:0]  beat_q;

    // ---------------- pixel FIFO ----------------
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          push_req, pop_req, fifo_full, fifo_empty, push_ok, pop_ok, fifo_clr;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign push_req   = pix_valid && (fst_q == ST_CAPT) && (pix_cnt_q != frame_words_q);
    assign pop_req    = wvalid_q & m_axi_wready_i;
    assign push_ok    = push_req & ~fifo_full;
    assign pop_ok     = pop_req & ~fifo_empty;
    // Leftover words from a frame that overflowed must not leak into the next one
    assign fifo_clr   = (fst_q == ST_ARM);

    always_ff @(posedge aclk_i) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= pix_word;
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    // ---------------- frame FSM ----------------
    logic frame_done;
    assign frame_done = (fst_q == ST_DRAIN) && (bst_q == BS_IDLE) && (cnt_q < BURST_CNT);

    always_comb begin
        frame_words_d = FW_VGA;
        case (resol_i)
            2'b01:   frame_words_d = FW_XGA;
            2'b10:   frame_words_d = FW_SXGA;
            default: frame_words_d = FW_VGA;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            fst_q         <= ST_IDLE;
            frame_words_q <= '0;
            pix_cnt_q     <= '0;
        end else begin
            case (fst_q)
                ST_IDLE: if (capon_q && vsync_fall) fst_q <= ST_ARM;
                ST_ARM: begin
                    frame_words_q <= frame_words_d;
                    pix_cnt_q     <= '0;
                    fst_q         <= ST_CAPT;
                end
                ST_CAPT: begin
                    // dropped (overflowed) pixels still count toward the frame
                    if (push_req) pix_cnt_q <= pix_cnt_q + 32'd1;
                    if (pix_cnt_q == frame_words_q) fst_q <= ST_DRAIN;
                end
                ST_DRAIN: if (frame_done) fst_q <= ST_IDLE;
                default:  fst_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------- burst FSM ----------------
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            bst_q     <= BS_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            beat_q    <= '0;
            awaddr_q  <= '0;
        end else begin
            if (fst_q == ST_ARM) awaddr_q <= MEMBASE + capaddr_q;
            case (bst_q)
                BS_IDLE: if (cnt_q >= BURST_CNT && !fifo_clr) begin
                    awvalid_q <= 1'b1;
                    bst_q     <= BS_AW;
                end
                BS_AW: if (m_axi_awready_i) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    beat_q    <= '0;
                    awaddr_q  <= awaddr_q + ADDR_STEP;
                    bst_q     <= BS_W;
                end
                BS_W: if (m_axi_wready_i) begin
                    beat_q <= beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) begin
                        wvalid_q <= 1'b0;
                        bst_q    <= BS_B;
                    end
                end
                BS_B:    if (m_axi_bvalid_i) bst_q <= BS_IDLE;
                default: bst_q <= BS_IDLE;
            endcase
        end
    end

    // ---------------- register file ----------------
    logic wr_addr, wr_ctrl, wr_int, wr_fifo;
    assign wr_addr = wren_i && (wraddr_i == A_CAPADDR);
    assign wr_ctrl = wren_i && (wraddr_i == A_CAPCTRL) && byteen_i[0];
    assign wr_int  = wren_i && (wraddr_i == A_CAPINT)  && byteen_i[0];
    assign wr_fifo = wren_i && (wraddr_i == A_CAPFIFO) && byteen_i[0];

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            capaddr_q <= '0;
            capon_q   <= 1'b0;
            irqen_q   <= 1'b0;
            irqst_q   <= 1'b0;
            over_q    <= 1'b0;
            under_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_addr) begin
                for (int b = 0; b < 4; b++)
                    if (byteen_i[b]) capaddr_q[8*b +: 8] <= wdata_i[8*b +: 8];
            end
            if (wr_ctrl) capon_q <= wdata_i[0];
            if (wr_int)  irqen_q <= wdata_i[0];
            // set sources win over same-cycle write-1-to-clear
            if (frame_done)                 irqst_q <= 1'b1;
            else if (wr_int && wdata_i[1])  irqst_q <= 1'b0;
            if (push_req && fifo_full)      over_q  <= 1'b1;
            else if (wr_fifo && wdata_i[0]) over_q  <= 1'b0;
            if (pop_req && fifo_empty)      under_q <= 1'b1;
            else if (wr_fifo && wdata_i[1]) under_q <= 1'b0;

            rdata_q <= '0;
            if (rden_i) begin
                case (rdaddr_i)
                    A_CAPADDR: rdata_q <= capaddr_q;
                    A_CAPCTRL: rdata_q <= {31'd0, capon_q};
                    A_CAPINT:  rdata_q <= {30'd0, irqst_q, irqen_q};
                    A_CAPFIFO: rdata_q <= {30'd0, under_q, over_q};
                    default:   rdata_q <= '0;
                endcase
            end
        end
    end

    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp_i;

    assign rdata_capt_o     = rdata_q;
    assign cap_irq_o        = irqen_q & irqst_q;
    assign cap_fifo_over_o  = over_q;
    assign cap_fifo_under_o = under_q;
    assign m_axi_awaddr_o   = awaddr_q;
    assign m_axi_awlen_o    = awvalid_q ? LAST_BEAT : 8'd0;
    assign m_axi_awsize_o   = awvalid_q ? 3'd2 : 3'd0;
    assign m_axi_awburst_o  = awvalid_q ? 2'b01 : 2'b00;
    assign m_axi_awvalid_o  = awvalid_q;
    assign m_axi_wdata_o    = wvalid_q ? fifo_mem[rd_ptr_q] : 32'd0;
    assign m_axi_wstrb_o    = wvalid_q ? 4'hF : 4'h0;
    assign m_axi_wlast_o    = wvalid_q && (beat_q == LAST_BEAT);
    assign m_axi_wvalid_o   = wvalid_q;
    assign m_axi_bready_o   = 1'b1;
endmodule

// File: tb/tb_capture_axi_writer.sv
module tb_capture_axi_writer;
    localparam logic [15:0] RB     = 16'h1000;
    localparam logic [15:0] A_ADDR = RB;
    localparam logic [15:0] A_CTRL = RB + 16'h4;
    localparam logic [15:0] A_INT  = RB + 16'h8;
    localparam logic [15:0] A_FIFO = RB + 16'hC;

    logic clk = 1'b0, aresetn = 1'b0;
    logic [1:0] resol = 2'b00;
    logic pclk = 1'b0, href = 1'b0, vsync = 1'b0;
    logic [7:0] camdata = '0;
    logic [15:0] wraddr = '0, rdaddr = '0;
    logic [3:0] byteen = '0;
    logic wren = 1'b0, rden = 1'b0;
    logic [31:0] wdata = '0, rdata;
    logic cap_irq, over, under;
    logic [31:0] awaddr, axi_wdata;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst, bresp = 2'b00;
    logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast, bvalid = 1'b0, bready;
    logic [3:0] wstrb;

    capture_axi_writer #(.FIFO_DEPTH(32), .VGA_W(16), .VGA_H(2), .XGA_W(16), .XGA_H(3),
                         .SXGA_W(32), .SXGA_H(2)) dut (
        .aclk_i(clk), .aresetn_i(aresetn), .resol_i(resol),
        .pclk_i(pclk), .href_i(href), .vsync_i(vsync), .camdata_i(camdata),
        .wraddr_i(wraddr), .rdaddr_i(rdaddr), .byteen_i(byteen), .wren_i(wren), .rden_i(rden),
        .wdata_i(wdata), .rdata_capt_o(rdata), .cap_irq_o(cap_irq),
        .cap_fifo_over_o(over), .cap_fifo_under_o(under),
        .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
        .m_axi_awburst_o(awburst), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(axi_wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
        .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready));

    initial forever #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int proto_err = 0, b_pending = 0, credit = 0, w_total = 0;
    bit prev_aw = 1'b0, aw_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] aw_list[$], got_data[$], got_addr[$], exp_q[$];

    // AXI slave: randomized readiness, transaction capture and protocol watch
    initial forever begin
        @(negedge clk);
        awready = aw_hold ? 1'b0 : 1'($urandom % 2);
        wready  = ($urandom % 4) != 0;
        bvalid  = (b_pending > 0) && ($urandom % 2 == 0);
        if (!aresetn) begin
            b_pending = 0; credit = 0; prev_aw = 1'b0; bvalid = 1'b0;
        end else begin
            if (prev_aw && (!awvalid || awaddr != prev_addr)) proto_err++;
            if (bvalid && bready) b_pending--;
            if (awvalid && awready) begin
                aw_list.push_back(awaddr);
                credit += 16;
                if (awlen != 8'd15 || awsize != 3'd2 || awburst != 2'b01) proto_err++;
            end
            prev_aw   = awvalid && !awready;
            prev_addr = awaddr;
            if (wvalid && wready) begin
                if (credit == 0) proto_err++; else credit--;
                if (wstrb != 4'hF) proto_err++;
                if (wlast != ((w_total % 16) == 15)) proto_err++;
                got_data.push_back(axi_wdata);
                if (w_total / 16 < aw_list.size())
                    got_addr.push_back(aw_list[w_total / 16] + 32'(4 * (w_total % 16)));
                else
                    got_addr.push_back('x);
                w_total++;
                if (wlast) b_pending++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb_expand(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return 32'(r * 65536 + g * 256 + b);
    endfunction

    task automatic reg_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        wraddr = a; wdata = d; byteen = be; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
        rdaddr = a; rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        d = rdata;
    endtask

    task automatic send_byte(input logic [7:0] b);
        camdata = b; pclk = 1'b0;
        repeat (4) @(negedge clk);
        pclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // action 1: clear CAPON at pixel stop_at; action 2: pulse reset there
    task automatic send_frame(input int w, input int h, input bit record, input bit use_fixed,
                              input logic [15:0] fixed, input int stop_at, input int action);
        logic [15:0] p;
        int idx = 0;
        vsync = 1'b1;
        repeat (6) @(negedge clk);
        vsync = 1'b0;
        repeat (10) @(negedge clk);
        for (int y = 0; y < h; y++) begin
            href = 1'b1;
            for (int x = 0; x < w; x++) begin
                p = use_fixed ? fixed : 16'($urandom);
                if (record) exp_q.push_back(rgb_expand(p));
                send_byte(p[15:8]);
                send_byte(p[7:0]);
                idx++;
                if (idx == stop_at && action == 1) reg_write(A_CTRL, 32'h0, 4'hF);
                if (idx == stop_at && action == 2) begin
                    chk("awvalid_before_reset", 32'(awvalid), 32'd1);
                    @(negedge clk); #2 aresetn = 1'b0;
                    #1;
                    chk("awvalid_in_reset", 32'(awvalid), 32'd0);
                    chk("wvalid_in_reset", 32'(wvalid), 32'd0);
                    @(negedge clk); #2 aresetn = 1'b1;
                end
            end
            href = 1'b0; pclk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic wait_irqst(input string tag);
        logic [31:0] d = '0;
        for (int i = 0; i < 600; i++) begin
            reg_read(A_INT, d);
            if (d[1]) break;
        end
        chk(tag, 32'(d[1]), 32'd1);
    endtask

    task automatic check_frame(input int ws, input int as_, input int n, input logic [31:0] base);
        chk("beat_count", 32'(got_data.size() - ws), 32'(n));
        chk("burst_count", 32'(aw_list.size() - as_), 32'(n / 16));
        for (int i = 0; i < n; i++) begin
            if (ws + i < got_data.size()) begin
                chk("wdata", got_data[ws + i], exp_q[i]);
                chk("waddr", got_addr[ws + i], 32'h2000_0000 + base + 32'(4 * i));
            end
        end
        chk("protocol", 32'(proto_err), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        int ws, as_, n_aw;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_wdata", axi_wdata, 32'd0);
        chk("rst_irq", 32'(cap_irq), 32'd0);
        chk("rst_flags", {30'd0, under, over}, 32'd0);
        chk("rst_bready", 32'(bready), 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);
        reg_read(A_ADDR, d); chk("rst_capaddr", d, 32'd0);
        reg_read(A_CTRL, d); chk("rst_capctrl", d, 32'd0);
        reg_read(A_INT, d);  chk("rst_capint", d, 32'd0);
        reg_read(A_FIFO, d); chk("rst_capfifo", d, 32'd0);

        reg_write(A_CTRL, 32'hFFFF_FFFF, 4'hF);
        reg_read(A_CTRL, d); chk("capctrl_mask", d, 32'd1);
        reg_write(A_ADDR, 32'h0, 4'hF);
        reg_read(RB + 16'h10, d); chk("unmapped_read", d, 32'd0);
        @(negedge clk); chk("rdata_idle", rdata, 32'd0);

        // frame 1: VGA-sized, solid red
        resol = 2'b00; ws = got_data.size(); as_ = aw_list.size();
        send_frame(16, 2, 1'b1, 1'b1, 16'hF800, -1, 0);
        wait_irqst("frame1_done");
        chk("red_word", (ws < got_data.size()) ? got_data[ws] : 32'hx, 32'h00FF_0000);
        check_frame(ws, as_, 32, 32'h0);
        chk("irq_masked", 32'(cap_irq), 32'd0);
        reg_write(A_INT, 32'h1, 4'hF); chk("irq_enabled", 32'(cap_irq), 32'd1);
        reg_write(A_INT, 32'h2, 4'hF); chk("irq_cleared", 32'(cap_irq), 32'd0);
        reg_read(A_INT, d); chk("capint_after_clr", d, 32'd0);

        // frame 2: XGA-sized, offset base, partial byte-enable write
        reg_write(A_ADDR, 32'hAABB_1000, 4'b0011);
        reg_read(A_ADDR, d); chk("capaddr_byteen", d, 32'h0000_1000);
        reg_write(A_INT, 32'h1, 4'hF);
        resol = 2'b01; ws = got_data.size(); as_ = aw_list.size();
        send_frame(16, 3, 1'b1, 1'b0, 16'h0, -1, 0);
        wait_irqst("frame2_done");
        chk("first_awaddr", (as_ < aw_list.size()) ? aw_list[as_] : 32'hx, 32'h2000_1000);
        check_frame(ws, as_, 48, 32'h1000);
        chk("irq_frame2", 32'(cap_irq), 32'd1);
        reg_write(A_INT, 32'h3, 4'hF); chk("irq_frame2_clr", 32'(cap_irq), 32'd0);

        // frame 3: SXGA-sized
        reg_write(A_ADDR, 32'h40, 4'hF);
        resol = 2'b10; ws = got_data.size(); as_ = aw_list.size();
        send_frame(32, 2, 1'b1, 1'b0, 16'h0, -1, 0);
        wait_irqst("frame3_done");
        check_frame(ws, as_, 64, 32'h40);
        reg_write(A_INT, 32'h2, 4'hF);

        // overflow: address channel stalled for the whole frame
        aw_hold = 1'b1;
        send_frame(32, 2, 1'b0, 1'b0, 16'h0, -1, 0);
        chk("over_flag", 32'(over), 32'd1);
        reg_read(A_FIFO, d); chk("capfifo_over", d, 32'd1);
        aw_hold = 1'b0;
        wait_irqst("overflow_frame_done");
        reg_write(A_FIFO, 32'h1, 4'hF);
        reg_read(A_FIFO, d); chk("capfifo_clr", d, 32'd0);
        chk("over_clr", 32'(over), 32'd0);
        chk("under_flag", 32'(under), 32'd0);
        reg_write(A_INT, 32'h2, 4'hF);

        // CAPON dropped mid-frame: frame completes, nothing afterwards
        reg_write(A_ADDR, 32'h0, 4'hF);
        resol = 2'b00; ws = got_data.size(); as_ = aw_list.size();
        send_frame(16, 2, 1'b1, 1'b0, 16'h0, 10, 1);
        wait_irqst("capoff_frame_done");
        check_frame(ws, as_, 32, 32'h0);
        reg_read(A_CTRL, d); chk("capon_off", d, 32'd0);
        reg_write(A_INT, 32'h2, 4'hF);
        n_aw = aw_list.size();
        send_frame(16, 2, 1'b0, 1'b0, 16'h0, -1, 0);
        repeat (100) @(negedge clk);
        chk("no_aw_after_capoff", 32'(aw_list.size()), 32'(n_aw));
        reg_read(A_INT, d); chk("no_irq_after_capoff", d, 32'd0);

        // reset with an address phase pending
        reg_write(A_ADDR, 32'h80, 4'hF);
        reg_write(A_CTRL, 32'h1, 4'hF);
        aw_hold = 1'b1;
        send_frame(16, 2, 1'b0, 1'b0, 16'h0, 20, 2);
        aw_hold = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_awvalid", 32'(awvalid), 32'd0);
        chk("post_rst_awaddr", awaddr, 32'd0);
        reg_read(A_CTRL, d); chk("post_rst_capctrl", d, 32'd0);
        reg_read(A_ADDR, d); chk("post_rst_capaddr", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
